// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, funct
// codes, ALU operation classes, ALU control codes, mux select codes and the
// controller state encoding (also visible on state_o for debug).
package mips_multicycle_ctrl_pkg;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [2:0] ALUC_AND = 3'b000;
   localparam logic [2:0] ALUC_OR  = 3'b001;
   localparam logic [2:0] ALUC_ADD = 3'b010;
   localparam logic [2:0] ALUC_SUB = 3'b110;
   localparam logic [2:0] ALUC_SLT = 3'b111;

   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10
   } alu_op_e;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_ADDIEX = 4'd9,
      ST_ADDIWB = 4'd10,
      ST_JUMP   = 4'd11
   } state_e;

   // Opcodes that only exist when the extended instruction set is enabled.
   function automatic logic is_ext_op(input logic [5:0] op);
      return (op == OP_BNE) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// ALU decoder for the multicycle MIPS controller (purely combinational).
// Ports:
//   alu_op      in   operation class: add, sub, or decode from funct
//   funct       in   instr[5:0], used only for the funct class
//   alu_control out  ALU operation code, upper bits above [2:0] always zero
module mips_multicycle_ctrl_alu_decoder
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W = 3
) (
   input  alu_op_e                 alu_op,
   input  logic [5:0]              funct,
   output logic [ALU_CTRL_W-1:0]   alu_control
);

   logic [2:0] ctl;

   always_comb begin
      ctl = ALUC_ADD;
      case (alu_op)
         ALU_OP_ADD: ctl = ALUC_ADD;
         ALU_OP_SUB: ctl = ALUC_SUB;
         ALU_OP_FUNCT: begin
            // Unknown funct codes fall back to add without flagging.
            case (funct)
               FN_ADD:  ctl = ALUC_ADD;
               FN_SUB:  ctl = ALUC_SUB;
               FN_AND:  ctl = ALUC_AND;
               FN_OR:   ctl = ALUC_OR;
               FN_SLT:  ctl = ALUC_SLT;
               default: ctl = ALUC_ADD;
            endcase
         end
         default: ctl = ALUC_ADD;
      endcase
      alu_control = ALU_CTRL_W'(ctl);
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main control unit for the multicycle MIPS datapath: Moore FSM with a
// variable-latency memory handshake, plus the ALU decoder.
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   op, funct             instr[31:26], instr[5:0]
//   zero                  ALU zero flag (branch resolution)
//   mem_ready             memory access completes this cycle
//   i_or_d .. pc_src      datapath mux selects and write strobes
//   pc_en                 PC load enable
//   alu_control           ALU operation
//   state_o               current state encoding (debug)
//   illegal_op            sticky unknown-opcode flag, cleared by reset
//
// state  | meaning
// FETCH  | read instruction, PC <= PC+4 when memory ready
// DECODE | read registers, precompute branch target, dispatch on op
// MEMADR | compute load/store address
// MEMRD  | load data read, held until memory ready
// MEMWB  | write loaded data to rt
// MEMWR  | store data write, held until memory ready
// EXEC   | R-type ALU operation
// ALUWB  | write ALU result to rd
// BRANCH | compare operands, take beq/bne
// ADDIEX | rs + sign-extended immediate
// ADDIWB | write addi result to rt
// JUMP   | load jump target into PC
module mips_multicycle_ctrl
   import mips_multicycle_ctrl_pkg::*;
#(
   parameter int ALU_CTRL_W  = 3,
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit EXT_EN      = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [5:0]             op,
   input  logic [5:0]             funct,
   input  logic                   zero,
   input  logic                   mem_ready,
   output logic                   i_or_d,
   output logic                   mem_write,
   output logic                   ir_write,
   output logic                   reg_dst,
   output logic                   mem_to_reg,
   output logic                   reg_write,
   output logic                   alu_src_a,
   output logic [1:0]             alu_src_b,
   output logic [1:0]             pc_src,
   output logic                   pc_en,
   output logic [ALU_CTRL_W-1:0]  alu_control,
   output logic [3:0]             state_o,
   output logic                   illegal_op
);

   state_e  state_q, state_d;
   logic    illegal_op_q, illegal_op_d;
   alu_op_e alu_op;
   logic    pc_write;
   logic    branch;
   logic    is_bne;
   logic    mem_rdy;
   logic    op_legal;

   // Gating with reset keeps the FETCH strobes (ir_write, pc_en) quiet while
   // reset is held, so no load happens after reset asserts.
   assign mem_rdy = (MEM_WAIT_EN ? mem_ready : 1'b1) & reset;

   assign op_legal = ((op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
                      (op == OP_BEQ) || is_ext_op(op)) &&
                     (EXT_EN || !is_ext_op(op));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_FETCH;
         illegal_op_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         illegal_op_q <= illegal_op_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      illegal_op_d = illegal_op_q;
      alu_op       = ALU_OP_ADD;
      i_or_d       = 1'b0;
      mem_write    = 1'b0;
      ir_write     = 1'b0;
      reg_dst      = 1'b0;
      mem_to_reg   = 1'b0;
      reg_write    = 1'b0;
      alu_src_a    = 1'b0;
      alu_src_b    = 2'b00;
      pc_src       = 2'b00;
      pc_write     = 1'b0;
      branch       = 1'b0;
      is_bne       = 1'b0;
      case (state_q)
         ST_FETCH: begin
            alu_src_b = SRCB_FOUR;
            ir_write  = mem_rdy;
            pc_write  = mem_rdy;
            if (mem_rdy) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            alu_src_b = SRCB_IMM_SH2;
            state_d   = ST_FETCH;
            if (!op_legal) begin
               illegal_op_d = 1'b1;
            end else begin
               case (op)
                  OP_LW, OP_SW:   state_d = ST_MEMADR;
                  OP_RTYPE:       state_d = ST_EXEC;
                  OP_BEQ, OP_BNE: state_d = ST_BRANCH;
                  OP_ADDI:        state_d = ST_ADDIEX;
                  OP_J:           state_d = ST_JUMP;
                  default:        state_d = ST_FETCH;
               endcase
            end
         end
         ST_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = (op == OP_SW) ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            i_or_d = 1'b1;
            if (mem_rdy) state_d = ST_MEMWB;
         end
         ST_MEMWB: begin
            mem_to_reg = 1'b1;
            reg_write  = 1'b1;
            state_d    = ST_FETCH;
         end
         ST_MEMWR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            if (mem_rdy) state_d = ST_FETCH;
         end
         ST_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_FUNCT;
            state_d   = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_dst   = 1'b1;
            reg_write = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = ALU_OP_SUB;
            pc_src    = PCSRC_ALUOUT;
            branch    = 1'b1;
            is_bne    = op[0];
            state_d   = ST_FETCH;
         end
         ST_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = SRCB_IMM;
            state_d   = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            reg_write = 1'b1;
            state_d   = ST_FETCH;
         end
         ST_JUMP: begin
            pc_src   = PCSRC_JUMP;
            pc_write = 1'b1;
            state_d  = ST_FETCH;
         end
         default: state_d = ST_FETCH;
      endcase
   end

   // Branch taken when the compare result matches the branch sense.
   assign pc_en      = pc_write | (branch & (zero ^ is_bne));
   assign state_o    = state_q;
   assign illegal_op = illegal_op_q;

   mips_multicycle_ctrl_alu_decoder #(
      .ALU_CTRL_W (ALU_CTRL_W)
   ) u_alu_decoder (
      .alu_op      (alu_op),
      .funct       (funct),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
module tb_mips_multicycle_ctrl;

   // Debug state encoding as published on state_o.
   localparam int S_FETCH  = 0;
   localparam int S_DECODE = 1;
   localparam int S_MEMADR = 2;
   localparam int S_MEMRD  = 3;
   localparam int S_MEMWB  = 4;
   localparam int S_MEMWR  = 5;
   localparam int S_EXEC   = 6;
   localparam int S_ALUWB  = 7;
   localparam int S_BRANCH = 8;
   localparam int S_ADDIEX = 9;
   localparam int S_ADDIWB = 10;
   localparam int S_JUMP   = 11;

   logic       clk = 1'b0;
   logic       reset;
   logic [5:0] op, funct;
   logic       zero, mem_ready;

   logic       i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, pc_en, illegal_op;
   logic [1:0] alu_src_b, pc_src;
   logic [2:0] alu_control;
   logic [3:0] state_o;

   logic       n_i_or_d, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg, n_reg_write, n_alu_src_a, n_pc_en, n_illegal_op;
   logic [1:0] n_alu_src_b, n_pc_src;
   logic [4:0] n_alu_control;
   logic [3:0] n_state_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_ill;

   typedef struct {
      int   s;
      logic mr;
   } step_t;
   step_t q[$];

   typedef struct {
      logic [5:0] op;
      logic [5:0] funct;
      int         zero;
      int         wf;
      int         wm;
      int         exp_lat;
      logic [2:0] exp_alu;
      logic       exp_pe;
      logic       exp_ill;
   } vec_t;

   logic [5:0] legal_ops [7] = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
   logic [5:0] rfuncts   [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

   mips_multicycle_ctrl dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .i_or_d(i_or_d), .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .pc_src(pc_src), .pc_en(pc_en), .alu_control(alu_control),
      .state_o(state_o), .illegal_op(illegal_op)
   );

   mips_multicycle_ctrl #(.ALU_CTRL_W(5), .MEM_WAIT_EN(1'b0), .EXT_EN(1'b0)) dut_n (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .i_or_d(n_i_or_d), .mem_write(n_mem_write), .ir_write(n_ir_write), .reg_dst(n_reg_dst),
      .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write), .alu_src_a(n_alu_src_a),
      .alu_src_b(n_alu_src_b), .pc_src(n_pc_src), .pc_en(n_pc_en), .alu_control(n_alu_control),
      .state_o(n_state_o), .illegal_op(n_illegal_op)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_legal(input logic [5:0] o);
      return o inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h02};
   endfunction

   function automatic logic [2:0] ref_alu(input logic [5:0] f);
      case (f)
         6'h20:   return 3'b010;
         6'h22:   return 3'b110;
         6'h24:   return 3'b000;
         6'h25:   return 3'b001;
         6'h2A:   return 3'b111;
         default: return 3'b010;
      endcase
   endfunction

   // Expected output word for one cycle of a given instruction step.
   function automatic logic [18:0] exp_vec(input int s, input logic [5:0] o, input logic [5:0] f,
                                           input logic mr, input logic z);
      logic iod, mw, irw, rd, m2r, rw, sa, pe;
      logic [1:0] sb, ps;
      logic [2:0] ac;
      logic [3:0] st;
      iod = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; pe = 0;
      sb = 2'b00; ps = 2'b00; ac = 3'b010;
      st = 4'(s);
      case (s)
         S_FETCH:  begin sb = 2'b01; irw = mr; pe = mr; end
         S_DECODE: sb = 2'b11;
         S_MEMADR: begin sa = 1; sb = 2'b10; end
         S_MEMRD:  iod = 1;
         S_MEMWB:  begin m2r = 1; rw = 1; end
         S_MEMWR:  begin iod = 1; mw = 1; end
         S_EXEC:   begin sa = 1; ac = ref_alu(f); end
         S_ALUWB:  begin rd = 1; rw = 1; end
         S_BRANCH: begin sa = 1; ac = 3'b110; ps = 2'b01; pe = z ^ (o == 6'h05); end
         S_ADDIEX: begin sa = 1; sb = 2'b10; end
         S_ADDIWB: rw = 1;
         S_JUMP:   begin ps = 2'b10; pe = 1; end
         default:  st = 4'hF;
      endcase
      return {iod, mw, irw, rd, m2r, rw, sa, sb, ps, pe, ac, st};
   endfunction

   function automatic logic rnd1();
      return 1'($urandom_range(0, 1));
   endfunction

   // Cycle-by-cycle step list of one instruction, with wait cycles inserted,
   // followed by one idle FETCH cycle that shows the instruction has ended.
   task automatic build(input logic [5:0] o, input int wf, input int wm);
      q.delete();
      repeat (wf) q.push_back('{S_FETCH, 1'b0});
      q.push_back('{S_FETCH, 1'b1});
      q.push_back('{S_DECODE, rnd1()});
      if (is_legal(o)) begin
         case (o)
            6'h23: begin
               q.push_back('{S_MEMADR, rnd1()});
               repeat (wm) q.push_back('{S_MEMRD, 1'b0});
               q.push_back('{S_MEMRD, 1'b1});
               q.push_back('{S_MEMWB, rnd1()});
            end
            6'h2B: begin
               q.push_back('{S_MEMADR, rnd1()});
               repeat (wm) q.push_back('{S_MEMWR, 1'b0});
               q.push_back('{S_MEMWR, 1'b1});
            end
            6'h00: begin
               q.push_back('{S_EXEC, rnd1()});
               q.push_back('{S_ALUWB, rnd1()});
            end
            6'h08: begin
               q.push_back('{S_ADDIEX, rnd1()});
               q.push_back('{S_ADDIWB, rnd1()});
            end
            6'h02:   q.push_back('{S_JUMP, rnd1()});
            default: q.push_back('{S_BRANCH, rnd1()});
         endcase
      end
      q.push_back('{S_FETCH, 1'b0});
   endtask

   // zin: 0/1 fixed zero flag, 2 random per cycle.
   task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zin,
                            input int wf, input int wm,
                            output int lat, output logic [2:0] alu_ex, output logic pe_br);
      logic left;
      build(o, wf, wm);
      op = o;
      funct = f;
      lat = -1;
      left = 1'b0;
      alu_ex = 3'b000;
      pe_br = 1'b0;
      foreach (q[i]) begin
         @(negedge clk);
         mem_ready = q[i].mr;
         zero = (zin > 1) ? rnd1() : zin[0];
         #1;
         check("outputs", {i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                           alu_src_b, pc_src, pc_en, alu_control, state_o},
               exp_vec(q[i].s, o, f, q[i].mr, zero));
         check("illegal_op", illegal_op, exp_ill);
         if (state_o != 4'd0) left = 1'b1;
         else if (left && lat < 0) lat = i;
         if (q[i].s == S_EXEC) alu_ex = alu_control;
         if (q[i].s == S_BRANCH || q[i].s == S_JUMP) pe_br = pc_en;
         if (q[i].s == S_DECODE && !is_legal(o)) exp_ill = 1'b1;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b0;
      repeat (3) begin
         @(negedge clk);
         check("reset_state", state_o, 0);
         check("reset_illegal", illegal_op, 0);
         check("reset_state_n", n_state_o, 0);
      end
      reset = 1'b1;
      exp_ill = 1'b0;
   endtask

   initial begin
      vec_t vecs[19];
      int lat;
      logic [2:0] aex;
      logic pbr;
      logic [5:0] o, f;
      logic bad;

      reset = 1'b0; op = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b0; exp_ill = 1'b0;

      //          op     funct  z  wf wm lat alu     pe    ill
      vecs[0]  = '{6'h23, 6'h00, 0, 0, 0, 5, 3'b000, 1'b0, 1'b0};
      vecs[1]  = '{6'h23, 6'h00, 0, 2, 2, 9, 3'b000, 1'b0, 1'b0};
      vecs[2]  = '{6'h2B, 6'h00, 0, 0, 0, 4, 3'b000, 1'b0, 1'b0};
      vecs[3]  = '{6'h2B, 6'h00, 1, 1, 3, 8, 3'b000, 1'b0, 1'b0};
      vecs[4]  = '{6'h04, 6'h00, 1, 0, 0, 3, 3'b000, 1'b1, 1'b0};
      vecs[5]  = '{6'h04, 6'h00, 0, 0, 0, 3, 3'b000, 1'b0, 1'b0};
      vecs[6]  = '{6'h05, 6'h00, 1, 0, 0, 3, 3'b000, 1'b0, 1'b0};
      vecs[7]  = '{6'h05, 6'h00, 0, 1, 0, 4, 3'b000, 1'b1, 1'b0};
      vecs[8]  = '{6'h00, 6'h20, 0, 0, 0, 4, 3'b010, 1'b0, 1'b0};
      vecs[9]  = '{6'h00, 6'h22, 0, 0, 0, 4, 3'b110, 1'b0, 1'b0};
      vecs[10] = '{6'h00, 6'h24, 0, 0, 0, 4, 3'b000, 1'b0, 1'b0};
      vecs[11] = '{6'h00, 6'h25, 0, 0, 0, 4, 3'b001, 1'b0, 1'b0};
      vecs[12] = '{6'h00, 6'h2A, 0, 0, 0, 4, 3'b111, 1'b0, 1'b0};
      vecs[13] = '{6'h00, 6'h3F, 0, 0, 0, 4, 3'b010, 1'b0, 1'b0};
      vecs[14] = '{6'h08, 6'h00, 0, 0, 0, 4, 3'b000, 1'b0, 1'b0};
      vecs[15] = '{6'h02, 6'h00, 0, 0, 0, 3, 3'b000, 1'b1, 1'b0};
      vecs[16] = '{6'h02, 6'h00, 0, 2, 0, 5, 3'b000, 1'b1, 1'b0};
      vecs[17] = '{6'h3F, 6'h00, 0, 0, 0, 2, 3'b000, 1'b0, 1'b1};
      vecs[18] = '{6'h23, 6'h00, 0, 0, 1, 6, 3'b000, 1'b0, 1'b1};

      do_reset();

      for (int i = 0; i < 19; i++) begin
         run_instr(vecs[i].op, vecs[i].funct, vecs[i].zero, vecs[i].wf, vecs[i].wm, lat, aex, pbr);
         check($sformatf("latency[%0d]", i), 32'(lat), 32'(vecs[i].exp_lat));
         if (vecs[i].op == 6'h00) check($sformatf("alu_exec[%0d]", i), aex, vecs[i].exp_alu);
         if (vecs[i].op inside {6'h04, 6'h05, 6'h02}) check($sformatf("pc_en[%0d]", i), pbr, vecs[i].exp_pe);
         check($sformatf("illegal_after[%0d]", i), illegal_op, vecs[i].exp_ill);
      end

      // Randomized instruction stream against the step model.
      do_reset();
      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 19);
         o = (r == 19) ? (6'h30 | 6'($urandom_range(0, 15))) : legal_ops[r % 7];
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : rfuncts[$urandom_range(0, 4)];
         run_instr(o, f, 2, $urandom_range(0, 2), $urandom_range(0, 2), lat, aex, pbr);
      end

      // Reset asserted during a stalled store.
      do_reset();
      op = 6'h2B; funct = 6'h00;
      @(negedge clk); mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk); mem_ready = 1'b0; #1;
      check("sw_wait_state", state_o, S_MEMWR);
      check("sw_wait_mem_write", mem_write, 1);
      @(negedge clk); #1;
      check("sw_hold_mem_write", mem_write, 1);
      #1; reset = 1'b0; mem_ready = 1'b1; #1;
      check("rst_mem_write", mem_write, 0);
      check("rst_state", state_o, S_FETCH);
      check("rst_ir_write", ir_write, 0);
      check("rst_pc_en", pc_en, 0);
      @(negedge clk); reset = 1'b1; mem_ready = 1'b0;

      // Instance without wait handshake or extended opcodes, 5-bit alu_control.
      do_reset();
      op = 6'h00; funct = 6'h2A; mem_ready = 1'b0; #1;
      check("n_fetch_ir_write", n_ir_write, 1);
      check("main_fetch_ir_write", ir_write, 0);
      @(negedge clk); #1; check("n_decode", n_state_o, S_DECODE);
      @(negedge clk); #1; check("n_exec", n_state_o, S_EXEC);
      check("n_alu_control", n_alu_control, 5'b00111);
      @(negedge clk); #1; check("n_aluwb", n_state_o, S_ALUWB);
      @(negedge clk); op = 6'h02; #1; check("n_fetch", n_state_o, S_FETCH);
      @(negedge clk); #1; check("n_j_decode", n_state_o, S_DECODE);
      check("n_illegal_before", n_illegal_op, 0);
      @(negedge clk); #1; check("n_j_back", n_state_o, S_FETCH);
      check("n_illegal_j", n_illegal_op, 1);
      check("main_stalled", state_o, S_FETCH);
      check("main_illegal", illegal_op, 0);

      // Sweep every {op,funct}; no output may go unknown.
      do_reset();
      for (int k = 0; k < 4096; k++) begin
         {op, funct} = 12'(k);
         bad = 1'b0;
         repeat (5) begin
            @(negedge clk);
            mem_ready = 1'b1;
            zero = rnd1();
            #1;
            bad |= $isunknown({i_or_d, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a,
                               alu_src_b, pc_src, pc_en, alu_control, state_o, illegal_op,
                               n_i_or_d, n_mem_write, n_ir_write, n_reg_dst, n_mem_to_reg, n_reg_write,
                               n_alu_src_a, n_alu_src_b, n_pc_src, n_pc_en, n_alu_control, n_state_o,
                               n_illegal_op});
         end
         check($sformatf("no_x[%03h]", k), bad, 0);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
